// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arbiter_pkg
//  Description : Shared definitions for the RAM arbiter: transaction FSM
//                state encoding and default requester count / address width /
//                data width.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_arbiter_pkg;

    // Default geometry
    localparam int c_nreq_default = 4;    // number of requesters
    localparam int c_aw_default   = 15;   // RAM address width
    localparam int c_dw_default   = 16;   // RAM data width

    // Transaction FSM: one arbitration cycle, one address/write cycle, one
    // read-data cycle.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage : ram_arbiter_pkg
`default_nettype wire

// File: rtl/ram_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational rotating-priority selector. Starting at index
//                ptr and walking upward modulo NREQ, the first set request
//                bit wins.
//  Ports       : req   - request vector (already masked by the caller)
//                ptr   - index holding highest priority this cycle
//                gnt   - one-hot winner (all zero when nothing is requested)
//                valid - at least one request was found
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import ram_arbiter_pkg::*;
#(
    parameter int NREQ = c_nreq_default,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic            valid
);

    logic [NREQ-1:0] w_gnt;
    logic            w_found;

    // For every possible pointer value the search order is a fixed rotation,
    // so all indices below are elaboration-time constants; the live pointer
    // only selects which rotation is active.
    always_comb begin
        w_gnt   = '0;
        w_found = 1'b0;
        for (int p = 0; p < NREQ; p++) begin
            if (ptr == PW'(p)) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!w_found && req[(p + i) % NREQ]) begin
                        w_gnt[(p + i) % NREQ] = 1'b1;
                        w_found               = 1'b1;
                    end
                end
            end
        end
    end

    assign gnt   = w_gnt;
    assign valid = w_found;

endmodule : rr_pick
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arbiter
//  Description : Round-robin arbiter giving NREQ requesters access to one
//                shared single-port synchronous RAM. Every transaction takes
//                exactly three cycles: arbitrate (IDLE), present address and
//                optional write strobe (ISSUE), capture read data (RESP).
//  Ports       : clock, reset         - clock / synchronous active-high reset
//                req, we, addr, din   - per-requester request, write enable,
//                                       address and write data (flattened,
//                                       slice k at [k*AW +: AW] / [k*DW +: DW])
//                gnt                  - one-hot grant held for the transaction
//                ack                  - one-cycle completion pulse
//                dout                 - last read data, broadcast
//                mem_addr, mem_din,
//                mem_we, mem_dout     - RAM port (read data one cycle late)
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int NREQ = c_nreq_default,
    parameter int AW   = c_aw_default,
    parameter int DW   = c_dw_default
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] din,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  ack,
    output logic [DW-1:0]    dout,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_din,
    output logic             mem_we,
    input  logic [DW-1:0]    mem_dout
);

    localparam int              c_pw   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [c_pw-1:0] c_last = c_pw'(NREQ - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t          r_state;
    logic [c_pw-1:0] r_ptr;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_ack;
    logic [DW-1:0]   r_dout;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_din;
    logic            r_mem_we;
    logic            r_is_write;   // remembers direction after mem_we drops

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    // A requester being acked this cycle has not yet had a chance to drop its
    // request, so it is kept out of this arbitration round.
    logic [NREQ-1:0] w_elig;
    logic [NREQ-1:0] w_win;
    logic            w_valid;

    assign w_elig = req & ~r_ack;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (c_pw)
    ) u_rr_pick (
        .req   (w_elig),
        .ptr   (r_ptr),
        .gnt   (w_win),
        .valid (w_valid)
    );

    // Winner index and its sampled request fields.
    logic [c_pw-1:0] w_idx;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_din;
    logic            w_we;
    logic [c_pw-1:0] w_ptr_nxt;

    always_comb begin
        w_idx  = '0;
        w_addr = '0;
        w_din  = '0;
        w_we   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win[i]) begin
                w_idx  = c_pw'(i);
                w_addr = addr[i*AW +: AW];
                w_din  = din[i*DW +: DW];
                w_we   = we[i];
            end
        end
    end

    // Priority moves to the requester just after the winner, wrapping at NREQ.
    assign w_ptr_nxt = (w_idx == c_last) ? '0 : w_idx + c_pw'(1);

    // ------------------------------------------------------------------------
    // Transaction FSM (all outputs registered)
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_gnt      <= '0;
            r_ack      <= '0;
            r_dout     <= '0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_mem_we   <= 1'b0;
            r_is_write <= 1'b0;
        end else begin
            // ack is a single-cycle pulse; only the RESP exit re-asserts it.
            r_ack <= '0;

            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_gnt      <= w_win;
                        r_mem_addr <= w_addr;
                        r_mem_din  <= w_din;
                        r_mem_we   <= w_we;
                        r_is_write <= w_we;
                        r_ptr      <= w_ptr_nxt;
                        r_state    <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    // Exactly one write strobe per write; address stays put
                    // while the RAM produces read data.
                    r_mem_we <= 1'b0;
                    r_state  <= ST_RESP;
                end

                ST_RESP: begin
                    r_ack <= r_gnt;
                    r_gnt <= '0;
                    if (!r_is_write) begin
                        r_dout <= mem_dout;
                    end
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_mem_we <= 1'b0;
                    r_gnt    <= '0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt      = r_gnt;
    assign ack      = r_ack;
    assign dout     = r_dout;
    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;
    assign mem_we   = r_mem_we;

endmodule : ram_arbiter
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_arbiter
//  Description : Self-checking bench for ram_arbiter. A transaction-level
//                reference model (round-robin search by modular arithmetic,
//                a shadow memory and a cycles-since-grant counter) predicts
//                every output each cycle; directed sequences and randomized
//                requester traffic drive the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 15;
    localparam int DW   = 16;
    localparam int DEPTH = 1 << AW;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [NREQ-1:0]    req   = '0;
    logic [NREQ-1:0]    we    = '0;
    logic [NREQ*AW-1:0] addr  = '0;
    logic [NREQ*DW-1:0] din   = '0;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic [DW-1:0]      dout;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_din;
    logic               mem_we;
    logic [DW-1:0]      mem_dout;

    ram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .din      (din),
        .gnt      (gnt),
        .ack      (ack),
        .dout     (dout),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_we   (mem_we),
        .mem_dout (mem_dout)
    );

    always #5 clock = ~clock;

    // ------------------------------------------------------------------------
    // RAM: synchronous, read data one cycle after address; unwritten
    // locations return an address-derived pattern.
    // ------------------------------------------------------------------------
    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return {a[7:0], ~a[7:0]} ^ 16'h3C3C;
    endfunction

    logic [DW-1:0] ram [0:DEPTH-1];
    bit            ram_vld [0:DEPTH-1];
    logic          pl_en   = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    always @(posedge clock) begin
        if (pl_en) begin
            ram[pl_addr]     <= pl_data;
            ram_vld[pl_addr] <= 1'b1;
        end else if (mem_we) begin
            ram[mem_addr]     <= mem_din;
            ram_vld[mem_addr] <= 1'b1;
        end
        mem_dout <= ram_vld[mem_addr] ? ram[mem_addr] : dflt(mem_addr);
    end

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    logic [DW-1:0]   sh [0:DEPTH-1];
    bit              sh_vld [0:DEPTH-1];
    int              m_age = 0;        // cycles since grant, 0 = free
    int              m_ptr = 0;
    int              m_k   = 0;
    bit              m_wr  = 1'b0;
    logic [NREQ-1:0] m_gnt = '0;
    logic [NREQ-1:0] m_ack = '0;
    logic [DW-1:0]   m_dout = '0;
    logic [AW-1:0]   m_mem_addr = '0;
    logic [DW-1:0]   m_mem_din  = '0;
    logic            m_mem_we   = 1'b0;

    function automatic logic [DW-1:0] sh_rd(input logic [AW-1:0] a);
        return sh_vld[a] ? sh[a] : dflt(a);
    endfunction

    task automatic model_step();
        logic [NREQ-1:0] elig;
        int k;
        int j;
        if (m_mem_we) begin
            sh[m_mem_addr]     = m_mem_din;
            sh_vld[m_mem_addr] = 1'b1;
        end
        if (reset) begin
            m_age = 0; m_ptr = 0; m_gnt = '0; m_ack = '0; m_dout = '0;
            m_mem_addr = '0; m_mem_din = '0; m_mem_we = 1'b0;
        end else begin
            elig  = req & ~m_ack;
            m_ack = '0;
            if (m_age == 0) begin
                if (elig != '0) begin
                    k = -1;
                    for (int i = 0; i < NREQ; i++) begin
                        j = (m_ptr + i) % NREQ;
                        if (k < 0 && elig[j]) k = j;
                    end
                    m_k        = k;
                    m_gnt      = '0;
                    m_gnt[k]   = 1'b1;
                    m_mem_addr = addr[k*AW +: AW];
                    m_mem_din  = din[k*DW +: DW];
                    m_mem_we   = we[k];
                    m_wr       = we[k];
                    m_ptr      = (k + 1) % NREQ;
                    m_age      = 1;
                end
            end else if (m_age == 1) begin
                m_mem_we = 1'b0;
                m_age    = 2;
            end else begin
                m_ack      = '0;
                m_ack[m_k] = 1'b1;
                m_gnt      = '0;
                if (!m_wr) m_dout = sh_rd(m_mem_addr);
                m_age = 0;
            end
        end
    endtask

    // ------------------------------------------------------------------------
    // Checking and bookkeeping
    // ------------------------------------------------------------------------
    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int n_wr   = 0;
    logic [AW-1:0] last_wr_addr = '0;
    logic [DW-1:0] last_wr_data = '0;
    int ack_q[$];
    int ack_t[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        @(negedge clock);
        cyc++;
        chk("gnt",      32'(gnt),      32'(m_gnt));
        chk("ack",      32'(ack),      32'(m_ack));
        chk("dout",     32'(dout),     32'(m_dout));
        chk("mem_addr", 32'(mem_addr), 32'(m_mem_addr));
        chk("mem_din",  32'(mem_din),  32'(m_mem_din));
        chk("mem_we",   32'(mem_we),   32'(m_mem_we));
        if (mem_we === 1'b1) begin
            n_wr++;
            last_wr_addr = mem_addr;
            last_wr_data = mem_din;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i] === 1'b1) begin
                ack_q.push_back(i);
                ack_t.push_back(cyc);
            end
        end
    endtask

    // Requesters drop req after seeing ack unless hold is set.
    task automatic run(input int n, input bit hold);
        for (int c = 0; c < n; c++) begin
            cycle();
            if (!hold) req = req & ~ack;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic clr_log();
        ack_q.delete();
        ack_t.delete();
        n_wr = 0;
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        // Reset, preloading RAM[5] = 0x1234 while the arbiter is held idle.
        reset   = 1'b1;
        pl_en   = 1'b1;
        pl_addr = AW'(5);
        pl_data = 16'h1234;
        sh[5]     = 16'h1234;
        sh_vld[5] = 1'b1;
        cycle();
        pl_en = 1'b0;
        cycle();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        reset = 1'b0;

        // Single read from requester 0.
        req = 4'b0001; we = '0;
        addr[0*AW +: AW] = AW'(5);
        cycle(); chk("rd_gnt1", 32'(gnt), 32'h1);
        cycle(); chk("rd_gnt2", 32'(gnt), 32'h1);
        cycle(); chk("rd_ack",  32'(ack), 32'h1);
        chk("rd_dout", 32'(dout), 32'h1234);
        req = '0;
        cycle();

        // Single write from requester 2; dout must keep the read value.
        clr_log();
        req = 4'b0100; we = 4'b0100;
        addr[2*AW +: AW] = AW'(16'h0010);
        din[2*DW +: DW]  = 16'hBEEF;
        run(4, 1'b0);
        chk("wr_pulses", 32'(n_wr), 32'd1);
        chk("wr_addr",   32'(last_wr_addr), 32'h0010);
        chk("wr_data",   32'(last_wr_data), 32'hBEEF);
        chk("wr_dout_kept", 32'(dout), 32'h1234);
        we = '0;

        // Pointer now sits at 3: requesters 3 and 0 -> 3 first, then 0.
        clr_log();
        req = 4'b1001;
        run(8, 1'b0);
        chk("p3_count", 32'(ack_q.size()), 32'd2);
        if (ack_q.size() == 2) begin
            chk("p3_first",  32'(ack_q[0]), 32'd3);
            chk("p3_second", 32'(ack_q[1]), 32'd0);
        end
        // Pointer now 1: requesters 0 and 1 -> 1 first.
        clr_log();
        req = 4'b0011;
        run(8, 1'b0);
        chk("p1_count", 32'(ack_q.size()), 32'd2);
        if (ack_q.size() == 2) chk("p1_first", 32'(ack_q[0]), 32'd1);

        // All four held continuously from reset.
        req = 4'b1111;
        do_reset();
        clr_log();
        run(24, 1'b1);
        chk("rr_count", 32'(ack_q.size()), 32'd8);
        for (int i = 0; i < ack_q.size(); i++) begin
            chk("rr_order", 32'(ack_q[i]), 32'(i % NREQ));
            if (i > 0) chk("rr_gap", 32'(ack_t[i] - ack_t[i-1]), 32'd3);
        end

        // Reset during the ISSUE cycle of a write.
        req = '0;
        do_reset();
        req = 4'b0100; we = 4'b0100;
        addr[2*AW +: AW] = AW'(16'h0020);
        din[2*DW +: DW]  = 16'hCAFE;
        cycle();
        chk("abort_issue_we", 32'(mem_we), 32'h1);
        reset = 1'b1;
        clr_log();
        cycle();
        reset = 1'b0;
        chk("abort_we",   32'(mem_we), 32'h0);
        chk("abort_gnt",  32'(gnt), 32'h0);
        chk("abort_ack",  32'(ack), 32'h0);
        chk("abort_dout", 32'(dout), 32'h0);
        run(6, 1'b0);
        chk("abort_reserve_count", 32'(ack_q.size()), 32'd1);
        if (ack_q.size() == 1) chk("abort_reserve_who", 32'(ack_q[0]), 32'd2);
        chk("abort_reserve_wr", 32'(n_wr), 32'd1);
        we = '0;
        req = '0;
        cycle();

        // Sole requester holding req through ack: masked one cycle, then new.
        clr_log();
        req = 4'b0001;
        run(12, 1'b1);
        chk("hold_count", 32'(ack_q.size()), 32'd3);
        if (ack_q.size() >= 2) chk("hold_gap", 32'(ack_t[1] - ack_t[0]), 32'd4);
        req = '0;
        cycle();

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(3) == 0) begin
                    we[i] = 1'($urandom_range(1));
                    addr[i*AW +: AW] = AW'($urandom_range(15));
                    din[i*DW +: DW]  = DW'($urandom);
                end
                if (req[i] && ack[i]) begin
                    if ($urandom_range(3) != 0) req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(2) == 0) begin
                    req[i] = 1'b1;
                end
            end
            reset = ($urandom_range(99) == 0);
            cycle();
        end
        reset = 1'b0;
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_ram_arbiter
`default_nettype wire

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL declare parameters: NREQ, default 4, number of requesters; AW, default 15, address width; DW, default 16, data width.
REQ-002 SHALL have port clock, input, 1, sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port req, input, NREQ, per-requester request level.
REQ-005 SHALL have port we, input, NREQ, per-requester write enable (1=write, 0=read).
REQ-006 SHALL have port addr, input, NREQ*AW, flattened requester addresses; slice k = bits [k*AW +: AW].
REQ-007 SHALL have port din, input, NREQ*DW, flattened requester write data; slice k = bits [k*DW +: DW].
REQ-008 SHALL have port gnt, output, NREQ, one-hot grant; held for the whole transaction.
REQ-009 SHALL have port ack, output, NREQ, one-cycle completion pulse for the granted requester.
REQ-010 SHALL have port dout, output, DW, read data broadcast to all requesters.
REQ-011 SHALL have ports mem_addr (output, AW), mem_din (output, DW), mem_we (output, 1), mem_dout (input, DW): shared single-port synchronous RAM, read data valid one cycle after address.

Function
REQ-012 SHALL implement FSM IDLE -> ISSUE -> RESP -> IDLE; each transaction exactly 3 cycles.
REQ-013 In IDLE, if any eligible req set, SHALL select winner k by round-robin from pointer ptr: search ptr, ptr+1, ... mod NREQ; first set bit wins.
REQ-014 On leaving IDLE SHALL register gnt=onehot(k), mem_addr=addr[k], mem_din=din[k], mem_we=we[k]; ptr <= (k+1) mod NREQ.
REQ-015 In ISSUE mem_we SHALL be high only if we[k] was sampled high; mem_we SHALL be 0 in all other states (exactly one write cycle per write).
REQ-016 On ISSUE->RESP edge SHALL clear mem_we; mem_addr held.
REQ-017 On RESP->IDLE edge SHALL assert ack[k] for one cycle, clear gnt, and, for reads only, load dout <= mem_dout; dout unchanged on writes and held until next read ack.
REQ-018 Latency: req sampled at edge E0 -> ack[k] high in cycle after edge E2.
REQ-019 During the cycle ack[k]=1, req[k] SHALL be masked from arbitration (requester drops req after seeing ack); a req still high one cycle later is a new request.
REQ-020 Inputs addr/din/we of requester k SHALL be sampled only at grant; later changes ignored.
REQ-021 No req set in IDLE: stay IDLE, outputs unchanged except ack=0.
REQ-022 req changes during ISSUE/RESP SHALL not affect the current transaction.
REQ-023 ptr wraps NREQ-1 -> 0; a continuously requesting set of N requesters each served once per N transactions.

Reset
REQ-024 reset high at a rising edge SHALL force: state IDLE, ptr 0, gnt 0, ack 0, mem_we 0, mem_addr 0, mem_din 0, dout 0.
REQ-025 Reset mid-transaction SHALL abort it with no ack and no further mem_we; a requester still holding req is re-arbitrated after reset.
REQ-026 reset SHALL override all other FSM activity in the same cycle.

Structure
REQ-027 Shared package/include SHALL hold FSM state encodings and default NREQ/AW/DW constants.
REQ-028 One sub-module rr_pick SHALL contain the combinational rotating priority select (inputs req-masked vector, ptr; outputs one-hot winner, valid).

Verification
REQ-029 Single read: req=0001, we=0, addr0=0x0005, RAM[5]=0x1234 -> gnt=0001 2 cycles, ack=0001 at cycle 3, dout=0x1234.
REQ-030 Single write: req=0100, we=0100, addr2=0x0010, din2=0xBEEF -> mem_we high exactly 1 cycle with mem_addr=0x0010, mem_din=0xBEEF; dout unchanged.
REQ-031 All four req held continuously from reset -> grant order 0,1,2,3,0,... each ack exactly 3 cycles apart.
REQ-032 req=1001 with ptr=3 -> requester 3 served first, then 0; ptr ends 1.
REQ-033 reset asserted in ISSUE of a write -> mem_we 0 next cycle, no ack, all outputs at reset values; held req re-served after reset.
REQ-034 Requester keeps req high through ack cycle -> masked in ack cycle, re-granted as new request next cycle if sole requester.
